// File: rtl/a_test_stream_check_pkg.sv
// Shared types and helpers for the a_test stream sink blocks.
package a_test_pkg;

    // Frame-tracking states of the stream checker.
    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    // Fibonacci feedback taps for x^16 + x^14 + x^13 + x^11 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input logic [63:0] max_val);
        return (cnt >= max_val) ? cnt : cnt + 64'd1;
    endfunction

endpackage : a_test_pkg

// File: rtl/a_test_stream_check_if.sv
// AXI-Stream bundle between the a_test source and its sinks.
interface axi_stream_inf #(
    parameter int unsigned DSIZE = 16
);
    logic [DSIZE-1:0] axis_tdata;
    logic             axis_tvalid;
    logic             axis_tlast;
    logic             axis_tready;

    modport master (
        output axis_tdata,
        output axis_tvalid,
        output axis_tlast,
        input  axis_tready
    );

    modport slave (
        input  axis_tdata,
        input  axis_tvalid,
        input  axis_tlast,
        output axis_tready
    );
endinterface : axi_stream_inf

// File: rtl/a_test_stream_check_lfsr_bp_gen.sv
// Free-running 16-bit Fibonacci LFSR used to throttle tready in sinks.
// lfsr_next is the value the register takes on the coming edge.
module lfsr_bp_gen
    import a_test_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        rst,
    output logic [15:0] lfsr_next
);

    logic [15:0] lfsr_q;

    // Shift left; the new LSB is the parity of the tapped bits.
    assign lfsr_next = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    // Advance every cycle, regardless of any handshake.
    always_ff @(posedge clock or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_next;
        end
    end

endmodule : lfsr_bp_gen

// File: rtl/a_test_stream_check.sv
// Self-checking AXI-Stream sink: expects tdata to count 0,1,2.. within each
// frame and frames of FRAME_LEN beats; counts frames, data and length errors.
module a_test_stream_check
    import a_test_pkg::*;
#(
    parameter int unsigned DSIZE      = 16,
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned NUM_FRAMES = 8,
    parameter int unsigned BP_MODE    = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             rst,
    axi_stream_inf.slave     origin_inf,
    input  logic             enable,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] data_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    output logic             err_flag,
    output logic             done
);

    localparam logic [63:0] CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
    localparam logic [31:0] LAST_IDX = 32'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [31:0]      beat_idx_q, beat_idx_d;
    logic             len_flag_q, len_flag_d;     // length error already counted for this frame
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] data_err_q, data_err_d;
    logic [CNT_W-1:0] len_err_q, len_err_d;
    logic             err_flag_q, err_flag_d;
    logic             done_q, done_d;
    logic             tready_q, tready_d;

    logic [15:0]      lfsr_next;
    logic             bp_bit;
    logic             accept;
    logic [DSIZE-1:0] tdata;
    logic             unused_lfsr_bits;

    lfsr_bp_gen #(
        .SEED (LFSR_SEED)
    ) u_lfsr_bp_gen (
        .clock     (clock),
        .rst       (rst),
        .lfsr_next (lfsr_next)
    );

    assign bp_bit           = (BP_MODE == 0) ? 1'b1 : lfsr_next[0];
    assign unused_lfsr_bits = ^lfsr_next[15:1];
    assign tdata            = origin_inf.axis_tdata;
    assign accept           = origin_inf.axis_tvalid & tready_q;

    // Next-state: pattern and length checks on each accepted beat, frame tracking.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        len_flag_d  = len_flag_q;
        frame_cnt_d = frame_cnt_q;
        data_err_d  = data_err_q;
        len_err_d   = len_err_q;
        err_flag_d  = err_flag_q;

        if (accept) begin
            if (tdata != DSIZE'(beat_idx_q)) begin
                data_err_d = CNT_W'(sat_inc(64'(data_err_q), CNT_MAX));
                err_flag_d = 1'b1;
            end

            if (origin_inf.axis_tlast) begin
                // Early tlast is an error; a late one was already counted when the frame overran.
                if ((beat_idx_q != LAST_IDX) && !len_flag_q) begin
                    len_err_d  = CNT_W'(sat_inc(64'(len_err_q), CNT_MAX));
                    err_flag_d = 1'b1;
                end
                frame_cnt_d = CNT_W'(sat_inc(64'(frame_cnt_q), CNT_MAX));
                beat_idx_d  = '0;
                len_flag_d  = 1'b0;
                if ((NUM_FRAMES != 0) && ((64'(frame_cnt_q) + 64'd1) == 64'(NUM_FRAMES))) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                // Final expected beat without tlast: flag once, keep consuming until tlast.
                if ((beat_idx_q == LAST_IDX) && !len_flag_q) begin
                    len_err_d  = CNT_W'(sat_inc(64'(len_err_q), CNT_MAX));
                    len_flag_d = 1'b1;
                    err_flag_d = 1'b1;
                end
                beat_idx_d = beat_idx_q + 32'd1;
                state_d    = RECV;
            end
        end

        done_d   = (state_d == DONE);
        tready_d = enable & ~done_d & bp_bit;
    end

    // State, counters and registered outputs; tready never depends on tvalid combinationally.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_idx_q  <= '0;
            len_flag_q  <= 1'b0;
            frame_cnt_q <= '0;
            data_err_q  <= '0;
            len_err_q   <= '0;
            err_flag_q  <= 1'b0;
            done_q      <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            len_flag_q  <= len_flag_d;
            frame_cnt_q <= frame_cnt_d;
            data_err_q  <= data_err_d;
            len_err_q   <= len_err_d;
            err_flag_q  <= err_flag_d;
            done_q      <= done_d;
            tready_q    <= tready_d;
        end
    end

    assign origin_inf.axis_tready = tready_q;
    assign frame_cnt              = frame_cnt_q;
    assign data_err_cnt           = data_err_q;
    assign len_err_cnt            = len_err_q;
    assign err_flag               = err_flag_q;
    assign done                   = done_q;

endmodule : a_test_stream_check

// File: doc/a_test_stream_check.md
Name: a_test_stream_check

Overview:
- Downstream consumer of the AXI-Stream produced by the a_test stimulus block. Sinks `origin_inf`.
- Checks each frame against an incrementing-data, fixed-length pattern and counts frames and errors.
- Applies optional pseudo-random backpressure.
- Used as the self-checking sink in the A_itgt integration bench and on hardware bring-up.

Parameters:
- DSIZE, 16: tdata width. Must equal the interface data width.
- FRAME_LEN, 64: expected beats per frame, 1..65535.
- NUM_FRAMES, 8: frames to accept before entering DONE. 0 means run forever.
- BP_MODE, 0: 0 = tready always asserted while enabled; 1 = tready gated by LFSR bit 0.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.
- CNT_W, 16: width of the status counters.

Ports:
- clock, input, 1: single clock domain.
- rst, input, 1: reset.
- origin_inf, axi_stream_inf.slave, -: uses axis_tdata[DSIZE-1:0], axis_tvalid and axis_tlast; drives axis_tready.
- enable, input, 1: accept beats when 1.
- frame_cnt, output, CNT_W: completed frames.
- data_err_cnt, output, CNT_W: beats with a data mismatch.
- len_err_cnt, output, CNT_W: frames with a wrong length.
- err_flag, output, 1: sticky; set on any error.
- done, output, 1: NUM_FRAMES frames received.

Behaviour:
- Clock and reset:
  - One clock: clock.
  - Reset is asynchronous and active-high: rst.
- Reset values:
  - axis_tready = 0; all counters = 0; err_flag = 0; done = 0.
  - State = IDLE; beat_idx = 0; LFSR = LFSR_SEED.
- Beat accept: a beat is accepted when axis_tvalid & axis_tready are both 1 at a rising edge.
- axis_tready generation:
  - Driven from a register, so it has no combinational dependence on tvalid.
  - Next value = enable & ~done_next & (BP_MODE==0 ? 1 : lfsr_next[0]).
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11.
  - Advances every cycle, independent of handshake.
- Pattern check:
  - Expected tdata = beat_idx modulo 2^DSIZE. beat_idx restarts at 0 every frame.
  - On mismatch: data_err_cnt +1 and err_flag set.
- Length check:
  - tlast on beat_idx != FRAME_LEN-1: len_err_cnt +1.
  - Accepted beat at beat_idx == FRAME_LEN-1 without tlast: len_err_cnt +1 once for that frame. Keep consuming until tlast; that frame does not count a second error.
  - A frame with both data and length errors increments both counters.
- Frame count: frame_cnt +1 on every accepted tlast beat, regardless of errors.
- Saturation: all counters saturate at 2^CNT_W-1; no wrap.
- Latency: counters and flags update on the clock edge that accepts the beat; visible the following cycle.
- States:
  - IDLE: waiting for the first beat of a frame.
    - Accept without tlast -> RECV.
    - Accept with tlast (1-beat frame) -> stays IDLE, or DONE if the count is reached.
  - RECV: mid-frame.
    - Accept with tlast -> IDLE, or DONE if frame_cnt+1 == NUM_FRAMES.
  - DONE: done = 1 and axis_tready = 0 from the next cycle onward.
    - Exited only by rst.
    - When NUM_FRAMES = 0, DONE is never entered.
- enable = 0 mid-frame: tready drops the next cycle; state and beat_idx are held; checking resumes seamlessly on re-enable.
- tvalid high with tready low: no state change. Data is not sampled.
- rst mid-frame: everything returns to reset values immediately. A frame partially received before reset is not counted. The next beat after reset is treated as beat 0.

Decomposition:
- Package a_test_pkg holds:
  - state enum {IDLE, RECV, DONE};
  - LFSR tap mask constant 16'hB400;
  - function sat_inc(cnt) for saturating increment.
- One sub-module, lfsr_bp_gen: seed parameter; clock and rst inputs; outputs lfsr_next[15:0]. Shared with other sinks.

Test Plan:
- NUM_FRAMES=8, FRAME_LEN=64, BP_MODE=0, clean source:
  - done rises after 512 beats; frame_cnt=8, both error counts 0, err_flag=0.
  - tready=0 on the cycle after the 512th beat.
- Corrupt beat 10 of frame 2 (tdata=0xFFFF):
  - data_err_cnt=1, len_err_cnt=0, frame_cnt=8, err_flag=1.
- Frame 3 with tlast at beat 40, then frame 4 with no tlast until beat 70:
  - len_err_cnt=2, frame_cnt=8.
  - Frame 5 checks clean, starting at tdata 0.
- BP_MODE=1, source holds tvalid high:
  - tready matches a reference LFSR model cycle for cycle.
  - No data is sampled while tready=0; error counts stay 0.
- Drop enable at beat 30 of frame 1 for 20 cycles, then raise it:
  - tready=0 during the gap; beat_idx resumes at 30; no errors.
- Assert rst at beat 20 of frame 5, then restart the source:
  - After reset, all counters = 0 and state = IDLE.
  - Then 8 clean frames -> done=1, frame_cnt=8.
- FRAME_LEN=1, NUM_FRAMES=4:
  - Four single-beat frames with tlast give frame_cnt=4 and done=1, with no errors.
